// File: rtl/dither_pkg.sv
// Shared types and constants for the frame-level RGB nibble quantizer.
// DITHER_ORDERED_EN adds the 4x4 position tag to each buffered pixel.
package dither_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dctl_state_t;

  // Indexed [y mod 4][x mod 4].
  localparam logic [3:0] BAYER4 [4][4] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6 },
    '{4'd3,  4'd11, 4'd1,  4'd9 },
    '{4'd15, 4'd7,  4'd13, 4'd5 }
  };

  // Round-half-up offset used when ordered dithering is off.
  localparam logic [3:0] K_ROUND = 4'd8;

  typedef struct packed {
    pixel_t     pix;
    logic       sof;
    logic       eol;
`ifdef DITHER_ORDERED_EN
    logic [1:0] px;
    logic [1:0] py;
`endif
  } fifo_ent_t;

endpackage

// File: rtl/dither_quantizer.sv
// Combinational 8-bit to 4-bit-per-channel quantizer: adds offset k, keeps the
// upper nibble, saturates to 0xF0 on overflow instead of wrapping.
import dither_pkg::*;

module dither_quantizer (
  input  pixel_t     pix_i,
  input  logic [3:0] k_i,
  output pixel_t     pix_o
);

  function automatic logic [7:0] quant_ch(input logic [7:0] c, input logic [3:0] k);
    logic [4:0] hi;
    hi = 5'(({1'b0, c} + {5'b0, k}) >> 4);
    return hi[4] ? 8'hF0 : {hi[3:0], 4'h0};
  endfunction

  assign pix_o.r = quant_ch(pix_i.r, k_i);
  assign pix_o.g = quant_ch(pix_i.g, k_i);
  assign pix_o.b = quant_ch(pix_i.b, k_i);

endmodule

// File: rtl/dither_frame_ctrl.sv
// Raster-order frame sequencer: reads the image memory, quantizes each pixel and
// streams it out through a 2-entry FIFO. Define DITHER_ORDERED_EN for Bayer dither.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_RUN   | issuing one memory read per pixel, credit-limited
// ST_DRAIN | all reads issued, waiting for FIFO and read pipe to empty
// ST_DONE  | one-cycle completion pulse
import dither_pkg::*;

module dither_frame_ctrl #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [23:0]       out_pixel,
  output logic              out_sof,
  output logic              out_eol
);

  localparam int XW = ($clog2(IMG_W) > 2) ? $clog2(IMG_W) : 2;
  localparam int YW = ($clog2(IMG_H) > 2) ? $clog2(IMG_H) : 2;
  localparam logic [XW-1:0]     X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(IMG_W * IMG_H - 1);

  dctl_state_t       state_q;
  logic              busy_q;
  logic              done_q;

  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDR_W-1:0] addr_q;

  logic              vld_q;
  logic              sof_p_q;
  logic              eol_p_q;
`ifdef DITHER_ORDERED_EN
  logic [1:0]        px_p_q;
  logic [1:0]        py_p_q;
`endif

  fifo_ent_t         fifo_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        cnt_q;

  logic              rd_en;
  logic              push;
  logic              pop;
  logic [1:0]        fill;
  logic              drained;
  logic [3:0]        k;
  pixel_t            q_pix;
  fifo_ent_t         wr_ent;
  fifo_ent_t         head;

  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push      = vld_q;

  // A slot freed by this cycle's pop is credited immediately so a steady
  // ready stream sustains one read per cycle without overrunning the FIFO.
  assign fill    = cnt_q - {1'b0, pop} + {1'b0, vld_q};
  assign rd_en   = (state_q == ST_RUN) && (fill < 2'd2);
  assign drained = !vld_q && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (rd_en && (addr_q == A_LAST)) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drained) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      sof_p_q <= 1'b0;
      eol_p_q <= 1'b0;
`ifdef DITHER_ORDERED_EN
      px_p_q  <= 2'd0;
      py_p_q  <= 2'd0;
`endif
    end else begin
      vld_q <= rd_en;
      if ((state_q == ST_IDLE) && start) begin
        x_q    <= '0;
        y_q    <= '0;
        addr_q <= '0;
      end else if (rd_en) begin
        sof_p_q <= (x_q == '0) && (y_q == '0);
        eol_p_q <= (x_q == X_LAST);
`ifdef DITHER_ORDERED_EN
        px_p_q  <= x_q[1:0];
        py_p_q  <= y_q[1:0];
`endif
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
        addr_q <= (addr_q == A_LAST) ? '0 : addr_q + 1'b1;
      end
    end
  end

`ifdef DITHER_ORDERED_EN
  assign k = BAYER4[py_p_q][px_p_q];
`else
  assign k = K_ROUND;
`endif

  dither_quantizer u_quant (
    .pix_i (pixel_t'(mem_data)),
    .k_i   (k),
    .pix_o (q_pix)
  );

  always_comb begin
    wr_ent     = '0;
    wr_ent.pix = q_pix;
    wr_ent.sof = sof_p_q;
    wr_ent.eol = eol_p_q;
`ifdef DITHER_ORDERED_EN
    wr_ent.px  = px_p_q;
    wr_ent.py  = py_p_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= wr_ent;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head      = fifo_q[rd_ptr_q];
  assign out_pixel = head.pix;
  assign out_sof   = head.sof;
  assign out_eol   = head.eol;

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd_en = rd_en;
  assign mem_addr  = addr_q;

endmodule

// File: tb/tb_dither_frame_ctrl.sv
// Directed bench for dither_frame_ctrl on a 4x2 image with a one-cycle-latency memory model.
module tb_dither_frame_ctrl;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_data = 24'h0;
  logic          out_valid;
  logic          out_ready;
  logic [23:0]   out_pixel;
  logic          out_sof;
  logic          out_eol;

  int n_checks = 0;
  int n_pass   = 0;
  int mode     = 0;

  always #5 clk = ~clk;

  dither_frame_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .out_sof   (out_sof),
    .out_eol   (out_eol)
  );

  // Mode 0: R={a,8}, G={a,0}, B=F8+a. Mode 1: constant F80807.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      if (mode == 0) mem_data <= {1'b0, mem_addr, 4'h8, 1'b0, mem_addr, 4'h0, 8'hF8 + {5'b0, mem_addr}};
      else           mem_data <= 24'hF80807;
    end
  end

  // Hand-derived mode-0 results: R nibble a+1 (a+1 only where k>=8 when dithered),
  // G nibble a, B always saturates or lands in the F nibble.
  function automatic logic [23:0] exp_pix(input logic [2:0] a);
    logic [3:0] rn;
`ifdef DITHER_ORDERED_EN
    logic [7:0] bump;
    bump = 8'b0101_1010;
    rn = {1'b0, a} + {3'b0, bump[a]};
`else
    rn = {1'b0, a} + 4'd1;
`endif
    return {rn, 4'h0, 1'b0, a, 4'h0, 8'hF0};
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, mem_rd_en, out_valid, out_sof, out_eol} !== 6'b0 || mem_addr !== 3'd0 || out_pixel !== 24'h0)
        $display("FAIL reset_outputs: busy=%b done=%b rd=%b valid=%b sof=%b eol=%b addr=%0d pix=%h, want all 0",
                 busy, done, mem_rd_en, out_valid, out_sof, out_eol, mem_addr, out_pixel);
      else n_pass++;
    end
    rst = 1'b0; start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, mem_rd_en, out_valid} !== 4'b0)
        $display("FAIL idle_no_start: busy=%b done=%b rd=%b valid=%b, want 0000", busy, done, mem_rd_en, out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_full_frame();
    logic exp_rd, exp_v;
    int a;
    mode = 0; out_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); start = 1'b0; #1;
      exp_rd = (c <= 8);
      exp_v  = (c >= 3) && (c <= 10);
      n_checks++;
      if (mem_rd_en !== exp_rd) $display("FAIL frame_rd_en c%0d: got %b want %b", c, mem_rd_en, exp_rd);
      else n_pass++;
      if (exp_rd) begin
        n_checks++;
        if (mem_addr !== 3'(c - 1)) $display("FAIL frame_addr c%0d: got %0d want %0d", c, mem_addr, c - 1);
        else n_pass++;
      end
      n_checks++;
      if (out_valid !== exp_v) $display("FAIL frame_valid c%0d: got %b want %b", c, out_valid, exp_v);
      else n_pass++;
      if (exp_v) begin
        a = c - 3;
        n_checks++;
        if (out_pixel !== exp_pix(3'(a))) $display("FAIL frame_pixel %0d: got %h want %h", a, out_pixel, exp_pix(3'(a)));
        else n_pass++;
        n_checks++;
        if ({out_sof, out_eol} !== {(a == 0), (a == 3 || a == 7)})
          $display("FAIL frame_tags %0d: got sof=%b eol=%b want sof=%b eol=%b", a, out_sof, out_eol, (a == 0), (a == 3 || a == 7));
        else n_pass++;
      end
      n_checks++;
      if ({busy, done} !== {(c <= 10), (c == 11)})
        $display("FAIL frame_busy_done c%0d: got busy=%b done=%b want busy=%b done=%b", c, busy, done, (c <= 10), (c == 11));
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    logic [23:0] p0, p1, e0;
    int got;
    logic done_seen;
    got = 0; done_seen = 1'b0; p0 = 24'h0; p1 = 24'h0;
    mode = 1; out_ready = 1'b1;
`ifdef DITHER_ORDERED_EN
    e0 = 24'hF00000;
`else
    e0 = 24'hF01000;
`endif
    @(negedge clk); start = 1'b1;
    for (int c = 0; c < 30 && !done_seen; c++) begin
      @(negedge clk); start = 1'b0; #1;
      if (out_valid) begin
        if (got == 0) p0 = out_pixel;
        if (got == 1) p1 = out_pixel;
        got++;
      end
      if (done) done_seen = 1'b1;
    end
    n_checks++;
    if (p0 !== e0) $display("FAIL sat_pixel0: got %h want %h", p0, e0);
    else n_pass++;
    n_checks++;
    if (p1 !== 24'hF01000) $display("FAIL sat_pixel1: got %h want %h", p1, 24'hF01000);
    else n_pass++;
    n_checks++;
    if (!done_seen || got != 8) $display("FAIL sat_frame_end: done_seen=%b pixels=%0d want 1 and 8", done_seen, got);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [25:0] held;
    logic holding, done_seen;
    int got, c;
    got = 0; c = 0; holding = 1'b0; done_seen = 1'b0; held = '0;
    mode = 0; out_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    while (!done_seen && c < 100) begin
      @(negedge clk); start = 1'b0; c++;
      out_ready = !((c >= 5) && (c <= 9));
      #1;
      if (holding) begin
        n_checks++;
        if (out_valid !== 1'b1 || {out_pixel, out_sof, out_eol} !== held)
          $display("FAIL bp_hold c%0d: got valid=%b data=%h want valid=1 data=%h", c, out_valid, {out_pixel, out_sof, out_eol}, held);
        else n_pass++;
      end
      if ((c >= 7) && (c <= 9)) begin
        n_checks++;
        if (mem_rd_en !== 1'b0) $display("FAIL bp_rd_stop c%0d: got %b want 0", c, mem_rd_en);
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (got >= 8 || out_pixel !== exp_pix(3'(got)))
          $display("FAIL bp_sequence %0d: got %h want %h", got, out_pixel, exp_pix(3'(got)));
        else n_pass++;
        got++;
      end
      holding = out_valid && !out_ready;
      held    = {out_pixel, out_sof, out_eol};
      if (done) done_seen = 1'b1;
    end
    out_ready = 1'b1;
    n_checks++;
    if (!done_seen || got != 8) $display("FAIL bp_frame_end: done_seen=%b pixels=%0d want 1 and 8", done_seen, got);
    else n_pass++;
  endtask

  task automatic test_start_and_abort();
    int got;
    logic done_seen, first_sof;
    got = 0; done_seen = 1'b0; first_sof = 1'b0;
    mode = 0; out_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    n_checks++;
    if ({busy, mem_rd_en} !== 2'b11 || mem_addr !== 3'd3 || out_pixel !== exp_pix(3'd1))
      $display("FAIL start_ignored: busy=%b rd=%b addr=%0d pix=%h want 1 1 3 %h", busy, mem_rd_en, mem_addr, out_pixel, exp_pix(3'd1));
    else n_pass++;
    rst = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if ({busy, out_valid, mem_rd_en, done} !== 4'b0 || out_pixel !== 24'h0)
      $display("FAIL abort_outputs: busy=%b valid=%b rd=%b done=%b pix=%h want all 0", busy, out_valid, mem_rd_en, done, out_pixel);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if ({busy, out_valid} !== 2'b0) $display("FAIL abort_stays_idle: busy=%b valid=%b want 00", busy, out_valid);
    else n_pass++;
    start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    n_checks++;
    if ({busy, mem_rd_en} !== 2'b11 || mem_addr !== 3'd0)
      $display("FAIL restart_addr: busy=%b rd=%b addr=%0d want 1 1 0", busy, mem_rd_en, mem_addr);
    else n_pass++;
    for (int c = 0; c < 30 && !done_seen; c++) begin
      if (out_valid) begin
        if (got == 0) first_sof = out_sof;
        n_checks++;
        if (got >= 8 || out_pixel !== exp_pix(3'(got)))
          $display("FAIL restart_sequence %0d: got %h want %h", got, out_pixel, exp_pix(3'(got)));
        else n_pass++;
        got++;
      end
      if (done) done_seen = 1'b1;
      @(negedge clk); #1;
    end
    n_checks++;
    if (!done_seen || got != 8 || first_sof !== 1'b1)
      $display("FAIL restart_frame_end: done_seen=%b pixels=%0d sof0=%b want 1 8 1", done_seen, got, first_sof);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_saturation();
    test_backpressure();
    test_start_and_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/dither_frame_ctrl.md
# dither_frame_ctrl

Frame-level controller that sequences the 24-bit RGB nibble quantizer over a whole image. On `start` it walks the image memory in raster order, issues one read per pixel, quantizes each returned pixel to 4 bits per channel, and presents the result on a valid/ready stream with start-of-frame and end-of-line markers. It sits between the image BRAM and the VGA/frame-buffer writer, and replaces ad-hoc per-pixel quantizer instantiation in the display path.

## Interface

Parameters:
- `IMG_W`, default 320: pixels per line.
- `IMG_H`, default 240: lines per frame.
- `ADDR_W`, default `$clog2(IMG_W*IMG_H)`: memory address width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse after the last pixel handshake.
- `mem_rd_en`  out  1  image memory read strobe.
- `mem_addr`  out  ADDR_W  read address, `y*IMG_W + x`.
- `mem_data`  in  24  pixel `{R,G,B}`, valid exactly 1 cycle after `mem_rd_en`.
- `out_valid`  out  1  output pixel valid.
- `out_ready`  in  1  downstream accepts.
- `out_pixel`  out  24  quantized `{R,G,B}`; low nibble of each channel is 0.
- `out_sof`  out  1  qualifies the pixel at (0,0).
- `out_eol`  out  1  qualifies pixels with x = IMG_W-1.

## Operation

- FSM states:
  - IDLE: `start` → RUN.
  - RUN: issues reads. After the read for address IMG_W*IMG_H-1 → DRAIN.
  - DRAIN: when the FIFO is empty and no read is in flight → DONE.
  - DONE: unconditionally → IDLE.
- `start` while not in IDLE is ignored.
- Read issue in RUN: `mem_rd_en` asserts only when (FIFO occupancy + in-flight reads) < 2. x/y counters advance on each issued read. x wraps at IMG_W-1 and increments y. Counters clear on entry to RUN.
- Returned data is quantized combinationally and written into a 2-entry output FIFO, together with its sof/eol tags and its (x mod 4, y mod 4) position.
- Output handshake:
  - The transfer occurs when `out_valid && out_ready`.
  - While `out_valid` is high and `out_ready` is low, `out_pixel`, `out_sof` and `out_eol` hold stable.
  - `out_valid` never drops without a handshake.
- Quantization per channel c (8 bit): compute `q = c + k` in 9 bits, where k is defined under Configuration. The result is `{q[7:4],4'h0}` if `q < 256`, otherwise `8'hF0`. The result saturates; it never wraps to 0.
- Reset values: `busy`=0, `done`=0, `mem_rd_en`=0, `mem_addr`=0, `out_valid`=0, `out_pixel`=0, `out_sof`=0, `out_eol`=0. FSM resets to IDLE and the FIFO to empty.
- `rst` mid-frame aborts the frame. Outputs take their reset values on the next edge, and in-flight memory data is discarded.

## Timing

- `start` is high in cycle 0 (IDLE). Cycle 1: `busy`=1, `mem_rd_en`=1, `mem_addr`=0. Cycle 2: `mem_data` is valid. Cycle 3: `out_valid`=1 with pixel 0 and `out_sof`=1.
- Latency from start to first `out_valid` is 3 cycles. Throughput is 1 pixel/cycle with `out_ready` held high.
- `done`=1 in the cycle after the final handshake. `busy` is 0 in that same cycle.
- `busy` is high from cycle 1 through the cycle of the final handshake.

## Configuration

- Macro `DITHER_ORDERED_EN`:
  - Defined: k = BAYER4[y mod 4][x mod 4], using 4x4 Bayer rows {0,8,2,10}, {12,4,14,6}, {3,11,1,9}, {15,7,13,5}.
  - Undefined: k = 8 (round half-up), and the position tag is not stored.

## Structure

- Package `dither_pkg`:
  - `pixel_t` (24-bit packed struct r/g/b).
  - State enum `dctl_state_t`.
  - Constant `BAYER4`.
  - Function-free constants only.
- Sub-module `dither_quantizer`: combinational; inputs pixel and k, output quantized pixel. It is instantiated once, between `mem_data` and the FIFO write.

## Test plan

- Reset: hold `rst` 3 cycles with `start`=1 → all outputs 0, no `mem_rd_en`. After release with `start` low, nothing happens.
- Full frame, IMG_W=4, IMG_H=2, `out_ready`=1, `mem_data`=addr replicated per channel:
  - `mem_addr` reads 0..7 in cycles 1..8.
  - `out_valid` is high in cycles 3..10.
  - `out_sof` accompanies pixel 0; `out_eol` accompanies pixels 3 and 7.
  - `done` pulses in cycle 11.
- Saturation, macro undefined: `mem_data`=0xF80807 → `out_pixel`=0xF01000. With the macro at (0,0) → 0xF00000; at (1,0), k=8 → 0xF01000.
- Backpressure: deassert `out_ready` for 5 cycles mid-frame:
  - `out_pixel` stays stable.
  - `mem_rd_en` stops within 2 cycles.
  - On resume, the pixel sequence is complete with no duplicates.
- `start` pulsed during RUN has no effect. `rst` asserted during RUN → next cycle `busy`=0 and `out_valid`=0; a new `start` restarts at address 0.
